pp_result_writer: RTL and testbench

//   Drains post-process results to the output feature-map SRAM. Accepts one LANES x int8

---
 rtl/pp_result_writer_if.sv | 13 +
 rtl/pp_result_writer.sv | 153 +++++++++++++++
 tb/tb_pp_result_writer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/pp_result_writer_if.sv
// SRAM write-beat bus between the result writer (master) and the feature-map SRAM (slave).
interface pp_result_writer_if #(
  parameter int ADDR_W   = 16,
  parameter int WR_BYTES = 4
);
  logic                    wr_en;
  logic [ADDR_W-1:0]       wr_addr;
  logic [WR_BYTES*8-1:0]   wr_data;
  logic                    wr_ready;

  modport master (output wr_en, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/pp_result_writer.sv
// Buffers LANES x int8 result vectors in a small FIFO and drains each one to SRAM as
// BEATS consecutive WR_BYTES-wide write beats, signalling all_done after cfg_count vectors.
//
// state  | meaning
// S_IDLE | waiting for cfg_start; input vectors are dropped
// S_RUN  | accepting vectors and issuing write beats
// S_DONE | last beat accepted; all_done pulses for this one cycle
module pp_result_writer #(
  parameter int LANES      = 32,
  parameter int WR_BYTES   = 4,
  parameter int ADDR_W     = 16,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start_i,
  input  logic [ADDR_W-1:0]    cfg_base_addr_i,
  input  logic [ADDR_W-1:0]    cfg_stride_i,
  input  logic [15:0]          cfg_count_i,
  input  logic                 in_valid_i,
  input  logic [LANES*8-1:0]   in_data_i,
  pp_result_writer_if.master   wr,
  output logic                 busy_o,
  output logic                 all_done_o,
  output logic                 overflow_o
);

  localparam int BEATS  = LANES / WR_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WORD_W = WR_BYTES * 8;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   vec_addr_q, stride_q;
  logic [15:0]         count_q, pushed_q, written_q;
  logic [BEAT_W-1:0]   beat_q;
  logic [LANES*8-1:0]  fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    fifo_cnt_q;
  logic                overflow_q;

  logic                wr_en_c, busy_c, all_done_c;
  logic                start, fifo_empty, fifo_full;
  logic                accept, last_beat, last_vec, pop, push, drop;
  logic [WORD_W-1:0]   head_words [BEATS];

  assign start      = cfg_start_i && (state_q == S_IDLE);
  assign fifo_empty = (fifo_cnt_q == '0);
  assign fifo_full  = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign accept     = wr_en_c && wr.wr_ready;
  assign last_beat  = (beat_q == BEAT_W'(BEATS - 1));
  assign last_vec   = (written_q == count_q - 16'd1);
  assign pop        = accept && last_beat;
  // Pushes are capped at cfg_count so surplus vectors never reach the SRAM.
  assign push       = in_valid_i && (state_q == S_RUN) && (pushed_q != count_q) &&
                      (!fifo_full || pop);
  assign drop       = in_valid_i && !push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = (cfg_count_i == 16'd0) ? S_DONE : S_RUN;
      S_RUN:   if (pop && last_vec) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_en_c    = 1'b0;
    busy_c     = 1'b0;
    all_done_c = 1'b0;
    case (state_q)
      S_RUN:  begin busy_c = 1'b1; wr_en_c = !fifo_empty; end
      S_DONE: begin busy_c = 1'b1; all_done_c = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_addr_q <= '0;
      stride_q   <= '0;
      count_q    <= '0;
      pushed_q   <= '0;
      written_q  <= '0;
      beat_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (start) begin
        vec_addr_q <= cfg_base_addr_i;
        stride_q   <= cfg_stride_i;
        count_q    <= cfg_count_i;
        pushed_q   <= '0;
        written_q  <= '0;
        beat_q     <= '0;
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push) begin
          wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          pushed_q <= pushed_q + 16'd1;
        end
        if (accept) begin
          if (last_beat) begin
            beat_q     <= '0;
            rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
            vec_addr_q <= vec_addr_q + stride_q;
            written_q  <= written_q + 16'd1;
          end else begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        case ({push, pop})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
          2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
          default: ;
        endcase
      end
      if (drop)       overflow_q <= 1'b1;
      else if (start) overflow_q <= 1'b0;
    end
  end

  // Storage only; validity is tracked by fifo_cnt_q, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= in_data_i;
  end

  for (genvar b = 0; b < BEATS; b++) begin : g_words
    assign head_words[b] = fifo_mem_q[rd_ptr_q][b*WORD_W +: WORD_W];
  end

  assign wr.wr_en    = wr_en_c;
  assign wr.wr_addr  = vec_addr_q + ADDR_W'(beat_q);
  assign wr.wr_data  = wr_en_c ? head_words[beat_q] : '0;
  assign busy_o      = busy_c;
  assign all_done_o  = all_done_c;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pp_result_writer.sv
// Directed bench for pp_result_writer: latency, backpressure, overflow, address wrap, reset abort.
module tb_pp_result_writer;
  localparam int LANES = 32, WR_BYTES = 4, ADDR_W = 16, FIFO_DEPTH = 2, BEATS = 8;

  logic                clk = 1'b0;
  logic                rst_n, cfg_start, in_valid;
  logic [15:0]         cfg_base_addr, cfg_stride, cfg_count;
  logic [LANES*8-1:0]  in_data;
  logic                busy, all_done, overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q_addr [$];
  logic [31:0] q_data [$];

  always #5 clk = ~clk;

  pp_result_writer_if #(.ADDR_W(ADDR_W), .WR_BYTES(WR_BYTES)) wr_if ();

  pp_result_writer #(.LANES(LANES), .WR_BYTES(WR_BYTES), .ADDR_W(ADDR_W),
                     .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start_i(cfg_start), .cfg_base_addr_i(cfg_base_addr),
    .cfg_stride_i(cfg_stride), .cfg_count_i(cfg_count), .in_valid_i(in_valid),
    .in_data_i(in_data), .wr(wr_if.master), .busy_o(busy), .all_done_o(all_done),
    .overflow_o(overflow)
  );

  // Accepted beats, sampled mid-cycle for the upcoming edge.
  always @(negedge clk) begin
    if (rst_n && wr_if.wr_en && wr_if.wr_ready) begin
      q_addr.push_back(wr_if.wr_addr);
      q_data.push_back(wr_if.wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [LANES*8-1:0] make_vec(input logic [7:0] seed);
    logic [LANES*8-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*8 +: 8] = seed + 8'(i);
    return v;
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] seed, input int k);
    logic [31:0] w;
    for (int b = 0; b < WR_BYTES; b++) w[b*8 +: 8] = seed + 8'(k*WR_BYTES + b);
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] base, input logic [15:0] stride,
                           input logic [15:0] count);
    cfg_base_addr = base;
    cfg_stride    = stride;
    cfg_count     = count;
    cfg_start     = 1'b1;
    step();
    cfg_start     = 1'b0;
  endtask

  task automatic push_vec(input logic [7:0] seed);
    in_data  = make_vec(seed);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!all_done && n < 300) begin
      step();
      n++;
    end
    chk(tag, all_done, 1'b1);
  endtask

  task automatic verify_job(input string tag, input logic [15:0] base, input logic [15:0] stride,
                            input int nvec, input logic [7:0] s0, input logic [7:0] s1,
                            input logic [7:0] s2);
    logic [7:0] seed;
    int idx;
    chk({tag, "_beats"}, q_addr.size(), nvec*BEATS);
    for (int v = 0; v < nvec; v++) begin
      seed = (v == 0) ? s0 : (v == 1) ? s1 : s2;
      for (int k = 0; k < BEATS; k++) begin
        idx = v*BEATS + k;
        if (idx < q_addr.size()) begin
          chk($sformatf("%s_addr%0d", tag, idx), q_addr[idx], 16'(base + v*stride + k));
          chk($sformatf("%s_data%0d", tag, idx), q_data[idx], exp_word(seed, k));
        end
      end
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        stall;
    logic [15:0] pa;
    logic [31:0] pd;
    int          n, n_stall;

    rst_n = 1'b0; cfg_start = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_base_addr = '0; cfg_stride = '0; cfg_count = '0;
    wr_if.wr_ready = 1'b1;

    // Reset state, then a stray vector in IDLE.
    #2;
    chk("rst_wr_en", wr_if.wr_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_all_done", all_done, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_wr_addr", wr_if.wr_addr, 16'h0);
    chk("rst_wr_data", wr_if.wr_data, 32'h0);
    step(); step();
    rst_n = 1'b1;
    step();
    push_vec(8'h55);
    chk("idle_overflow", overflow, 1'b1);
    chk("idle_wr_en", wr_if.wr_en, 1'b0);
    step();
    chk("idle_no_beats", q_addr.size(), 0);

    // Single vector: latency and lane packing.
    clear_log();
    start_job(16'h0100, 16'd8, 16'd1);
    chk("single_busy", busy, 1'b1);
    chk("single_ovf_clr", overflow, 1'b0);
    push_vec(8'h00);
    chk("single_first_en", wr_if.wr_en, 1'b1);
    chk("single_b0_addr", wr_if.wr_addr, 16'h0100);
    chk("single_b0_data", wr_if.wr_data, 32'h03020100);
    repeat (7) step();
    chk("single_b7_addr", wr_if.wr_addr, 16'h0107);
    chk("single_b7_data", wr_if.wr_data, 32'h1F1E1D1C);
    chk("single_b7_not_done", all_done, 1'b0);
    step();
    chk("single_done", all_done, 1'b1);
    chk("single_done_no_en", wr_if.wr_en, 1'b0);
    step();
    chk("single_done_1cyc", all_done, 1'b0);
    chk("single_idle", busy, 1'b0);
    verify_job("single", 16'h0100, 16'd8, 1, 8'h00, 8'h00, 8'h00);

    // Backpressure with wr_ready toggling; mid-job cfg_start must be ignored.
    clear_log();
    start_job(16'h0100, 16'd8, 16'd2);
    push_vec(8'h40);
    push_vec(8'h80);
    n = 0; n_stall = 0;
    while (!all_done && n < 200) begin
      wr_if.wr_ready = ~wr_if.wr_ready;
      stall = wr_if.wr_en && !wr_if.wr_ready;
      pa = wr_if.wr_addr;
      pd = wr_if.wr_data;
      if (n == 5) begin
        cfg_base_addr = 16'h0500;
        cfg_start = 1'b1;
      end
      step();
      cfg_start = 1'b0;
      if (stall) begin
        n_stall++;
        chk($sformatf("bp_addr_stable%0d", n), wr_if.wr_addr, pa);
        chk($sformatf("bp_data_stable%0d", n), wr_if.wr_data, pd);
      end
      n++;
    end
    chk("bp_done", all_done, 1'b1);
    chk("bp_saw_stall", n_stall != 0, 1'b1);
    wr_if.wr_ready = 1'b1;
    step();
    verify_job("bp", 16'h0100, 16'd8, 2, 8'h40, 8'h80, 8'h00);
    chk("bp_overflow", overflow, 1'b0);

    // FIFO full drop: third vector lost, job completes once a later vector arrives.
    clear_log();
    wr_if.wr_ready = 1'b0;
    start_job(16'hFFF0, 16'd8, 16'd3);
    push_vec(8'h11);
    step(); step();
    push_vec(8'h22);
    chk("ovf_two_ok", overflow, 1'b0);
    step(); step();
    push_vec(8'h33);
    chk("ovf_third_drop", overflow, 1'b1);
    chk("ovf_stalled_en", wr_if.wr_en, 1'b1);
    chk("ovf_no_beats", q_addr.size(), 0);
    wr_if.wr_ready = 1'b1;
    repeat (30) step();
    chk("ovf_drained16", q_addr.size(), 16);
    chk("ovf_still_busy", busy, 1'b1);
    push_vec(8'h44);
    wait_done("ovf_done");
    step();
    verify_job("ovf", 16'hFFF0, 16'd8, 3, 8'h11, 8'h22, 8'h44);

    // Address wrap within a vector, then an empty job.
    clear_log();
    start_job(16'hFFFC, 16'd8, 16'd1);
    push_vec(8'h60);
    wait_done("wrap_done");
    step();
    verify_job("wrap", 16'hFFFC, 16'd8, 1, 8'h60, 8'h00, 8'h00);
    start_job(16'h1234, 16'd8, 16'd0);
    chk("zero_done", all_done, 1'b1);
    chk("zero_no_en", wr_if.wr_en, 1'b0);
    step();
    chk("zero_done_1cyc", all_done, 1'b0);
    chk("zero_idle", busy, 1'b0);
    chk("zero_no_beats", q_addr.size(), 8);

    // Reset during beat 3, then a clean job.
    clear_log();
    start_job(16'h0200, 16'd8, 16'd1);
    push_vec(8'h70);
    repeat (3) step();
    chk("mid_b3_addr", wr_if.wr_addr, 16'h0203);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", wr_if.wr_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_addr", wr_if.wr_addr, 16'h0);
    step();
    chk("mid_rst_beats", q_addr.size(), 3);
    rst_n = 1'b1;
    step();
    chk("mid_after_en", wr_if.wr_en, 1'b0);
    clear_log();
    start_job(16'h0300, 16'd8, 16'd1);
    push_vec(8'h90);
    wait_done("mid_new_done");
    step();
    verify_job("mid_new", 16'h0300, 16'd8, 1, 8'h90, 8'h00, 8'h00);
    chk("mid_new_ovf", overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
